// File: rtl/am_ctrl_pkg.sv
// Shared types and helpers for the AM chain controller: FSM state codes,
// sample widths and the per-sample deviation from mid-scale.
package am_ctrl_pkg;

  localparam int DEV_W = 7;
  localparam int AD_W  = 8;
  localparam logic [AD_W-1:0] MID = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  // Distance from mid-scale; symmetric so 127 and 128 both give 0.
  function automatic logic [DEV_W-1:0] calc_dev(input logic [AD_W-1:0] d);
    return (d >= MID) ? DEV_W'(d - MID) : DEV_W'((MID - 1'b1) - d);
  endfunction

endpackage

// File: rtl/am_peak_win.sv
// Window counter, running peak deviation, latched window peak and win_end.
// With AM_CTRL_OVLD_EN defined, also counts rail hits (0/255) per window.
module am_peak_win
  import am_ctrl_pkg::*;
#(
  parameter int WIN_LEN = 1024
`ifdef AM_CTRL_OVLD_EN
  , parameter int OVLD_LIM = 8
`endif
) (
  input  logic             clk1,
  input  logic             sys_rst_n,
  input  logic             run_i,
  input  logic             run_nxt_i,
  input  logic [AD_W-1:0]  ad_data_i,
  output logic             win_end_o,
  output logic [DEV_W-1:0] win_peak_o,
  output logic [DEV_W-1:0] peak_level_o
`ifdef AM_CTRL_OVLD_EN
  , output logic           ovld_d_o
  , output logic           ovld_o
`endif
);

  localparam int CW = $clog2(WIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEV_W-1:0] run_pk_q, run_pk_d;
  logic [DEV_W-1:0] lvl_q, lvl_d;
  logic [DEV_W-1:0] dev;
  logic             win_end_q, win_end_d;

  // win_end is registered from the next count so it is high exactly while
  // sample WIN_LEN-1 is on ad_data; win_peak_o already includes that sample.
  always_comb begin
    dev        = calc_dev(ad_data_i);
    win_peak_o = (dev > run_pk_q) ? dev : run_pk_q;
    cnt_d      = run_i ? cnt_q + 1'b1 : '0;
    win_end_d  = run_nxt_i && (cnt_d == LAST);
    run_pk_d   = '0;
    lvl_d      = lvl_q;
    if (run_i) begin
      if (win_end_q) lvl_d = win_peak_o;
      else           run_pk_d = win_peak_o;
    end
  end

  always_ff @(posedge clk1 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      run_pk_q  <= '0;
      lvl_q     <= '0;
      win_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_pk_q  <= run_pk_d;
      lvl_q     <= lvl_d;
      win_end_q <= win_end_d;
    end
  end

  assign win_end_o    = win_end_q;
  assign peak_level_o = lvl_q;

`ifdef AM_CTRL_OVLD_EN
  localparam int RW = $clog2(WIN_LEN + 1);

  logic [RW-1:0] rail_q, rail_d, rail_sum;
  logic          ovld_q;
  logic          hit;

  always_comb begin
    hit      = (ad_data_i == '0) || (ad_data_i == '1);
    rail_sum = rail_q + RW'(hit);
    rail_d   = '0;
    ovld_d_o = ovld_q;
    if (run_i) begin
      if (win_end_q) ovld_d_o = (32'(rail_sum) > OVLD_LIM);
      else           rail_d   = rail_sum;
    end
  end

  always_ff @(posedge clk1 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rail_q <= '0;
      ovld_q <= 1'b0;
    end else begin
      rail_q <= rail_d;
      ovld_q <= ovld_d_o;
    end
  end

  assign ovld_o = ovld_q;
`endif

endmodule

// File: rtl/am_chain_ctrl.sv
// Sequencing/carrier-supervision FSM for the AM demod chain (IDLE/FLUSH/
// SEARCH/LOCK). AM_CTRL_OVLD_EN adds the ovld output and overload mute.
module am_chain_ctrl
  import am_ctrl_pkg::*;
#(
  parameter int WARMUP_CYC = 64,
  parameter int WIN_LEN    = 1024,
  parameter int ON_THRESH  = 16,
  parameter int OFF_THRESH = 8,
  parameter int LOSS_WINS  = 2
`ifdef AM_CTRL_OVLD_EN
  , parameter int OVLD_LIM = 8
`endif
) (
  input  logic             clk1,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [AD_W-1:0]  ad_data,
  input  logic             fir_valid,
  output logic             fir_sink_valid,
  output logic             da_mute,
  output logic             carrier_ok,
  output logic [DEV_W-1:0] peak_level,
  output logic [2:0]       state,
  output logic             win_end
`ifdef AM_CTRL_OVLD_EN
  , output logic           ovld
`endif
);

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int LW = $clog2(LOSS_WINS + 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    warm_q, warm_d, warm_inc;
  logic [LW-1:0]    weak_q, weak_d, weak_inc;
  logic             fsv_q, mute_q, ok_q, mute_d;
  logic [DEV_W-1:0] win_peak;
  logic             ovld_nxt;

  am_peak_win #(
    .WIN_LEN     (WIN_LEN)
`ifdef AM_CTRL_OVLD_EN
    , .OVLD_LIM  (OVLD_LIM)
`endif
  ) u_peak (
    .clk1        (clk1),
    .sys_rst_n   (sys_rst_n),
    .run_i       (state_q != ST_IDLE),
    .run_nxt_i   (state_d != ST_IDLE),
    .ad_data_i   (ad_data),
    .win_end_o   (win_end),
    .win_peak_o  (win_peak),
    .peak_level_o(peak_level)
`ifdef AM_CTRL_OVLD_EN
    , .ovld_d_o  (ovld_nxt)
    , .ovld_o    (ovld)
`endif
  );

`ifndef AM_CTRL_OVLD_EN
  assign ovld_nxt = 1'b0;
`endif

  // Later assignments override earlier ones: enable beats fir_valid loss,
  // which beats any window-driven transition.
  always_comb begin
    state_d  = state_q;
    warm_inc = warm_q + 1'b1;
    weak_inc = weak_q + 1'b1;
    warm_d   = warm_q;
    weak_d   = weak_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (fir_valid) begin
          warm_d = warm_inc;
          if (warm_inc == WW'(WARMUP_CYC)) state_d = ST_SEARCH;
        end else begin
          warm_d = '0;
        end
      end
      ST_SEARCH: if (win_end && (win_peak >= DEV_W'(ON_THRESH))) state_d = ST_LOCK;
      ST_LOCK: begin
        if (win_end) begin
          if (win_peak < DEV_W'(OFF_THRESH)) begin
            weak_d = weak_inc;
            if (weak_inc == LW'(LOSS_WINS)) state_d = ST_SEARCH;
          end else begin
            weak_d = '0;
          end
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (!fir_valid && ((state_q == ST_SEARCH) || (state_q == ST_LOCK))) state_d = ST_FLUSH;
    if (!enable) state_d = ST_IDLE;
    if (state_d != ST_FLUSH) warm_d = '0;
    if (state_d != ST_LOCK)  weak_d = '0;
    mute_d = (state_d != ST_LOCK) || ovld_nxt;
  end

  always_ff @(posedge clk1 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      weak_q  <= '0;
      fsv_q   <= 1'b0;
      mute_q  <= 1'b1;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      weak_q  <= weak_d;
      fsv_q   <= (state_d != ST_IDLE);
      mute_q  <= mute_d;
      ok_q    <= (state_d == ST_LOCK);
    end
  end

  // fir_sink_valid is a plain qualifier: high whenever the chain is running.
  assign fir_sink_valid = fsv_q;
  assign da_mute        = mute_q;
  assign carrier_ok     = ok_q;
  assign state          = {1'b0, state_q};

endmodule

// File: tb/tb_am_chain_ctrl.sv
// Directed bench for am_chain_ctrl (WARMUP_CYC=4, WIN_LEN=16); the overload
// cases run only when AM_CTRL_OVLD_EN is defined.
module tb_am_chain_ctrl;

  logic       clk1 = 1'b0;
  logic       sys_rst_n;
  logic       enable;
  logic [7:0] ad_data;
  logic       fir_valid;
  logic       fir_sink_valid;
  logic       da_mute;
  logic       carrier_ok;
  logic [6:0] peak_level;
  logic [2:0] state;
  logic       win_end;
`ifdef AM_CTRL_OVLD_EN
  logic       ovld;
`endif

  int n_vec;
  int n_err;
  logic alt;

  am_chain_ctrl #(
    .WARMUP_CYC(4),
    .WIN_LEN   (16),
    .ON_THRESH (16),
    .OFF_THRESH(8),
    .LOSS_WINS (2)
  ) dut (
    .clk1          (clk1),
    .sys_rst_n     (sys_rst_n),
    .enable        (enable),
    .ad_data       (ad_data),
    .fir_valid     (fir_valid),
    .fir_sink_valid(fir_sink_valid),
    .da_mute       (da_mute),
    .carrier_ok    (carrier_ok),
    .peak_level    (peak_level),
    .state         (state),
    .win_end       (win_end)
`ifdef AM_CTRL_OVLD_EN
    , .ovld        (ovld)
`endif
  );

  // clock
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic mute, input logic ok);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_mute"}, 32'(da_mute), 32'(mute));
    check({tag, "_ok"}, 32'(carrier_ok), 32'(ok));
  endtask

  // Drive one sample, let one rising edge pass, settle 1 time unit.
  task automatic step(input logic [7:0] d);
    ad_data = d;
    @(posedge clk1);
    #1;
  endtask

  task automatic step_alt();
    step(alt ? 8'd156 : 8'd100);
    alt = ~alt;
  endtask

  // One full 16-sample window starting at window sample 0, alternating a/b.
  task automatic run_window(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("win_end", 32'(win_end), 1);
      step(i[0] ? b : a);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    alt = 1'b0;
    sys_rst_n = 1'b0;
    enable = 1'b0;
    fir_valid = 1'b0;
    ad_data = 8'd128;
    repeat (3) @(posedge clk1);
    #1;

    // reset values
    chk_st("rst", 3'd0, 1'b1, 1'b0);
    check("rst_fsv", 32'(fir_sink_valid), 0);
    check("rst_peak", 32'(peak_level), 0);
    check("rst_win_end", 32'(win_end), 0);
    sys_rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      step(8'd128);
      chk_st("idle", 3'd0, 1'b1, 1'b0);
      check("idle_fsv", 32'(fir_sink_valid), 0);
    end

    // start-up: 4 FLUSH cycles, SEARCH, LOCK after first window
    enable = 1'b1;
    fir_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step_alt();
      if (k == 1) check("flush_fsv", 32'(fir_sink_valid), 1);
      if (k == 4) chk_st("flush4", 3'd1, 1'b1, 1'b0);
      if (k == 5) chk_st("search", 3'd2, 1'b1, 1'b0);
      if (k == 15) check("win_end_lo", 32'(win_end), 0);
      if (k == 16) check("win_end_hi", 32'(win_end), 1);
    end
    chk_st("lock", 3'd3, 1'b0, 1'b1);
    check("peak28", 32'(peak_level), 28);
    check("win_end_drop", 32'(win_end), 0);

    // loss: two weak windows
    run_window(8'd131, 8'd131);
    chk_st("weak1", 3'd3, 1'b0, 1'b1);
    check("peak3", 32'(peak_level), 3);
    run_window(8'd131, 8'd131);
    chk_st("weak2", 3'd2, 1'b1, 1'b0);

    // ON_THRESH boundary: 15 stays, 16 locks
    run_window(8'd143, 8'd112);
    chk_st("on15", 3'd2, 1'b1, 1'b0);
    check("peak15", 32'(peak_level), 15);
    run_window(8'd144, 8'd112);
    chk_st("on16", 3'd3, 1'b0, 1'b1);
    check("peak16", 32'(peak_level), 16);

    // OFF_THRESH boundary: 7 weak, 8 clears the weak count
    run_window(8'd135, 8'd121);
    chk_st("off7a", 3'd3, 1'b0, 1'b1);
    run_window(8'd136, 8'd128);
    chk_st("off8", 3'd3, 1'b0, 1'b1);
    check("peak8", 32'(peak_level), 8);
    run_window(8'd135, 8'd135);
    chk_st("off7b", 3'd3, 1'b0, 1'b1);
    run_window(8'd135, 8'd135);
    chk_st("off7c", 3'd2, 1'b1, 1'b0);
    run_window(8'd100, 8'd156);
    chk_st("relock", 3'd3, 1'b0, 1'b1);

    // between thresholds for 5 windows
    for (int w = 0; w < 5; w++) begin
      run_window(8'd140, 8'd116);
      chk_st("mid", 3'd3, 1'b0, 1'b1);
      check("peak12", 32'(peak_level), 12);
    end

    // weak interleaved with strong/mid windows
    for (int w = 0; w < 6; w++) begin
      if (w[0]) run_window((w == 3) ? 8'd140 : 8'd100, 8'd156);
      else      run_window(8'd131, 8'd131);
      chk_st("interleave", 3'd3, 1'b0, 1'b1);
    end

    // fir_valid glitch in LOCK, then another inside FLUSH
    alt = 1'b0;
    repeat (12) step_alt();
    fir_valid = 1'b0;
    step_alt();
    fir_valid = 1'b1;
    chk_st("glitch_lock", 3'd1, 1'b1, 1'b0);
    check("glitch_fsv", 32'(fir_sink_valid), 1);
    repeat (2) step_alt();
    check("flush_win_end", 32'(win_end), 1);
    fir_valid = 1'b0;
    step_alt();
    fir_valid = 1'b1;
    chk_st("glitch_flush", 3'd1, 1'b1, 1'b0);
    repeat (3) step_alt();
    chk_st("warm3", 3'd1, 1'b1, 1'b0);
    step_alt();
    chk_st("warm4", 3'd2, 1'b1, 1'b0);
    repeat (11) step_alt();
    check("search_win_end", 32'(win_end), 1);
    chk_st("search_wait", 3'd2, 1'b1, 1'b0);
    step_alt();
    chk_st("regain", 3'd3, 1'b0, 1'b1);

`ifdef AM_CTRL_OVLD_EN
    check("ovld_clean", 32'(ovld), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("ovld_win_end", 32'(win_end), 1);
      step((i < 9) ? 8'd255 : (i[0] ? 8'd156 : 8'd100));
    end
    check("ovld9", 32'(ovld), 1);
    chk_st("ovld9", 3'd3, 1'b1, 1'b1);
    run_window(8'd100, 8'd156);
    check("ovld_clear", 32'(ovld), 0);
    chk_st("ovld_clear", 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step((i < 8) ? 8'd0 : 8'd156);
    check("ovld8", 32'(ovld), 0);
    chk_st("ovld8", 3'd3, 1'b0, 1'b1);
`endif

    // enable drop from LOCK
    enable = 1'b0;
    step(8'd128);
    chk_st("disable", 3'd0, 1'b1, 1'b0);
    check("disable_fsv", 32'(fir_sink_valid), 0);
    enable = 1'b1;
    step(8'd100);
    chk_st("reenable", 3'd1, 1'b1, 1'b0);

    // asynchronous reset mid-cycle
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_st("arst", 3'd0, 1'b1, 1'b0);
    check("arst_fsv", 32'(fir_sink_valid), 0);
    check("arst_peak", 32'(peak_level), 0);
    enable = 1'b0;
    @(negedge clk1);
    sys_rst_n = 1'b1;
    step(8'd128);
    chk_st("post_rst", 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
